// File: rtl/countdown_timer_bcd.sv
// BCD MM:SS countdown timer: preset load, 1 Hz decrement to 00:00, done pulse and timed alarm level.
// Latency: Q and flags update one CP edge after the LOAD/START/PAUSE/EN cycle that causes them.
// Backpressure: none; EN is a free-running strobe. Optional CDT_AUTO_RELOAD_EN reloads the preset on expiry.
module countdown_timer_bcd #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic       LOAD,
    input  logic       START,
    input  logic       PAUSE,
    input  logic [7:0] PRESET_M,
    input  logic [7:0] PRESET_S,
    output logic [7:0] Q_M,
    output logic [7:0] Q_S,
    output logic       BUSY,
    output logic       DONE_P,
    output logic       ALARM,
    output logic       LOAD_ERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_TICKS);

    logic [1:0] state;
    logic [7:0] presetM;
    logic [7:0] presetS;
    logic [7:0] alarmCnt;
    logic [7:0] decM;
    logic [7:0] decS;
    logic       presetValid;
    logic       qZero;
    logic       nextZero;
    logic       reload;

    assign presetValid = (PRESET_M[7:4] <= 4'd5) && (PRESET_M[3:0] <= 4'd9) &&
                         (PRESET_S[7:4] <= 4'd5) && (PRESET_S[3:0] <= 4'd9);
    assign qZero    = (Q_M == 8'h00) && (Q_S == 8'h00);
    assign nextZero = (decM == 8'h00) && (decS == 8'h00);
    assign BUSY     = (state == RUN);

`ifdef CDT_AUTO_RELOAD_EN
    assign reload = (presetM != 8'h00) || (presetS != 8'h00);
`else
    assign reload = 1'b0;
`endif

    // Borrow chain; only consumed when Q is non-zero, so minute tens never wraps.
    always_comb begin
        decM = Q_M;
        decS = Q_S;
        if (Q_S[3:0] != 4'd0) begin
            decS[3:0] = Q_S[3:0] - 4'd1;
        end else begin
            decS[3:0] = 4'd9;
            if (Q_S[7:4] != 4'd0) begin
                decS[7:4] = Q_S[7:4] - 4'd1;
            end else begin
                decS[7:4] = 4'd5;
                if (Q_M[3:0] != 4'd0) begin
                    decM[3:0] = Q_M[3:0] - 4'd1;
                end else begin
                    decM[3:0] = 4'd9;
                    decM[7:4] = Q_M[7:4] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state    <= IDLE;
            Q_M      <= 8'h00;
            Q_S      <= 8'h00;
            presetM  <= 8'h00;
            presetS  <= 8'h00;
            alarmCnt <= 8'h00;
            DONE_P   <= 1'b0;
            ALARM    <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else begin
            DONE_P   <= 1'b0;
            LOAD_ERR <= 1'b0;
            if (LOAD && (state != RUN)) begin
                if (presetValid) begin
                    Q_M      <= PRESET_M;
                    Q_S      <= PRESET_S;
                    presetM  <= PRESET_M;
                    presetS  <= PRESET_S;
                    state    <= IDLE;
                    ALARM    <= 1'b0;
                    alarmCnt <= 8'h00;
                end else begin
                    LOAD_ERR <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (PAUSE) begin
                            state <= PAUSED;
                        end else if (EN && !qZero) begin
                            if (nextZero) DONE_P <= 1'b1;
                            if (nextZero && reload) begin
                                Q_M <= presetM;
                                Q_S <= presetS;
                            end else begin
                                Q_M <= decM;
                                Q_S <= decS;
                                if (nextZero) begin
                                    ALARM    <= 1'b1;
                                    alarmCnt <= ALARM_LOAD;
                                    state    <= DONE;
                                end
                            end
                        end
                    end
                    IDLE, PAUSED: begin
                        if (!PAUSE && START && !qZero) state <= RUN;
                    end
                    DONE: begin
                        if (EN) begin
                            alarmCnt <= alarmCnt - 8'd1;
                            if (alarmCnt <= 8'd1) begin
                                ALARM <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd; the reload section is selected by CDT_AUTO_RELOAD_EN.
module tb_countdown_timer_bcd;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       EN = 1'b0;
    logic       LOAD = 1'b0;
    logic       START = 1'b0;
    logic       PAUSE = 1'b0;
    logic [7:0] PRESET_M = 8'h00;
    logic [7:0] PRESET_S = 8'h00;
    logic [7:0] Q_M;
    logic [7:0] Q_S;
    logic       BUSY;
    logic       DONE_P;
    logic       ALARM;
    logic       LOAD_ERR;

    int errors = 0;
    int checks = 0;

    countdown_timer_bcd #(.ALARM_TICKS(10)) dut (
        .CP(CP), .CR(CR), .EN(EN), .LOAD(LOAD), .START(START), .PAUSE(PAUSE),
        .PRESET_M(PRESET_M), .PRESET_S(PRESET_S),
        .Q_M(Q_M), .Q_S(Q_S), .BUSY(BUSY), .DONE_P(DONE_P),
        .ALARM(ALARM), .LOAD_ERR(LOAD_ERR)
    );

    always #5 CP = ~CP;

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic loadPreset(input logic [7:0] m, input logic [7:0] s);
        PRESET_M = m;
        PRESET_S = s;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
    endtask

    task automatic pulseStart();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic pulsePause();
        PAUSE = 1'b1;
        step();
        PAUSE = 1'b0;
    endtask

    // EN high for one cycle then low for one; Q is sampled after the EN edge.
    task automatic enTick(output logic doneSeen);
        EN = 1'b1;
        step();
        doneSeen = DONE_P;
        EN = 1'b0;
        step();
    endtask

    initial begin
        logic d;
        int   doneCnt;
        logic [7:0] expS [7];

        // Reset with random inputs on the other pins
        CR = 1'b1;
        for (int i = 0; i < 2; i++) begin
            EN = 1'($urandom); LOAD = 1'($urandom); START = 1'($urandom); PAUSE = 1'($urandom);
            PRESET_M = 8'($urandom); PRESET_S = 8'($urandom);
            step();
        end
        CR = 1'b0; EN = 1'b0; LOAD = 1'b0; START = 1'b0; PAUSE = 1'b0;
        check("rst_q", {Q_M, Q_S}, 16'h0000);
        check("rst_busy", 16'(BUSY), 16'h0);
        check("rst_done", 16'(DONE_P), 16'h0);
        check("rst_alarm", 16'(ALARM), 16'h0);
        check("rst_lerr", 16'(LOAD_ERR), 16'h0);

`ifdef CDT_AUTO_RELOAD_EN
        loadPreset(8'h00, 8'h03);
        pulseStart();
        expS[0] = 8'h02; expS[1] = 8'h01; expS[2] = 8'h03; expS[3] = 8'h02;
        expS[4] = 8'h01; expS[5] = 8'h03; expS[6] = 8'h02;
        for (int i = 0; i < 7; i++) begin
            EN = 1'b1;
            step();
            EN = 1'b0;
            check("ar_q", {Q_M, Q_S}, {8'h00, expS[i]});
            check("ar_donep", 16'(DONE_P), 16'(expS[i] == 8'h03));
            check("ar_alarm", 16'(ALARM), 16'h0);
            check("ar_busy", 16'(BUSY), 16'h1);
            step();
        end
`else
        // Full countdown from 01:05
        loadPreset(8'h01, 8'h05);
        check("ld_q", {Q_M, Q_S}, 16'h0105);
        pulseStart();
        check("run_busy", 16'(BUSY), 16'h1);
        doneCnt = 0;
        for (int i = 0; i < 64; i++) begin
            enTick(d);
            doneCnt += int'(d);
        end
        check("cd_q64", {Q_M, Q_S}, 16'h0001);
        check("cd_nodone", 16'(doneCnt), 16'h0);
        EN = 1'b1;
        step();
        EN = 1'b0;
        check("exp_q", {Q_M, Q_S}, 16'h0000);
        check("exp_donep", 16'(DONE_P), 16'h1);
        check("exp_alarm", 16'(ALARM), 16'h1);
        check("exp_busy", 16'(BUSY), 16'h0);
        step();
        check("exp_donep_clr", 16'(DONE_P), 16'h0);
        doneCnt = 0;
        for (int i = 0; i < 9; i++) begin
            enTick(d);
            doneCnt += int'(d);
        end
        check("alm_hold", 16'(ALARM), 16'h1);
        check("alm_q_floor", {Q_M, Q_S}, 16'h0000);
        check("alm_nodone", 16'(doneCnt), 16'h0);
        enTick(d);
        check("alm_off", 16'(ALARM), 16'h0);
        check("alm_busy", 16'(BUSY), 16'h0);
        pulseStart();
        check("start_zero", 16'(BUSY), 16'h0);
        check("start_zero_q", {Q_M, Q_S}, 16'h0000);

        // Borrow chain
        loadPreset(8'h10, 8'h00);
        pulseStart();
        enTick(d);
        check("borrow_1000", {Q_M, Q_S}, 16'h0959);
        pulsePause();
        loadPreset(8'h00, 8'h10);
        check("ld_paused", {Q_M, Q_S}, 16'h0010);
        check("ld_paused_busy", 16'(BUSY), 16'h0);
        pulseStart();
        enTick(d);
        check("borrow_0010", {Q_M, Q_S}, 16'h0009);

        // LOAD while running is ignored silently
        loadPreset(8'h12, 8'h34);
        check("ld_run_q", {Q_M, Q_S}, 16'h0009);
        check("ld_run_lerr", 16'(LOAD_ERR), 16'h0);
        check("ld_run_busy", 16'(BUSY), 16'h1);

        // Invalid loads in IDLE
        pulsePause();
        loadPreset(8'h00, 8'h30);
        loadPreset(8'h00, 8'h6A);
        check("bad6A_lerr", 16'(LOAD_ERR), 16'h1);
        check("bad6A_q", {Q_M, Q_S}, 16'h0030);
        step();
        check("bad6A_pulse", 16'(LOAD_ERR), 16'h0);
        loadPreset(8'h00, 8'h75);
        check("bad75_lerr", 16'(LOAD_ERR), 16'h1);
        check("bad75_q", {Q_M, Q_S}, 16'h0030);
        step();

        // PAUSE beats EN in the same cycle
        pulseStart();
        PAUSE = 1'b1;
        EN = 1'b1;
        step();
        PAUSE = 1'b0;
        EN = 1'b0;
        check("pz_q", {Q_M, Q_S}, 16'h0030);
        check("pz_busy", 16'(BUSY), 16'h0);
        for (int i = 0; i < 5; i++) enTick(d);
        check("pz_hold", {Q_M, Q_S}, 16'h0030);
        pulseStart();
        check("pz_resume", 16'(BUSY), 16'h1);
        enTick(d);
        check("pz_dec", {Q_M, Q_S}, 16'h0029);

        // CR in the middle of a run
        pulsePause();
        loadPreset(8'h03, 8'h17);
        pulseStart();
        CR = 1'b1;
        step();
        CR = 1'b0;
        check("cr_q", {Q_M, Q_S}, 16'h0000);
        check("cr_busy", 16'(BUSY), 16'h0);

        // LOAD while in DONE clears the alarm
        loadPreset(8'h00, 8'h02);
        pulseStart();
        enTick(d);
        enTick(d);
        check("done2_donep", 16'(d), 16'h1);
        check("done2_alarm", 16'(ALARM), 16'h1);
        loadPreset(8'h00, 8'h45);
        check("ld_done_alarm", 16'(ALARM), 16'h0);
        check("ld_done_q", {Q_M, Q_S}, 16'h0045);
        check("ld_done_busy", 16'(BUSY), 16'h0);
        pulseStart();
        check("ld_done_restart", 16'(BUSY), 16'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
